// File: rtl/cnt_pkg.sv
// cnt_pkg: shared constants and next-state select encoding for the up/down counter
package cnt_pkg;
  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT = 1;
  typedef enum logic [2:0] {HOLD, CLR, LOAD, INC, DEC, WRAP_LO, WRAP_HI, SAT} sel_e;
endpackage

// File: rtl/updown_next_val.sv
// updown_next_val: combinational next count and boundary-hit for the up/down counter
module updown_next_val
  import cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int unsigned MAX_VAL = (1 << WIDTH) - 1,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] next_count,
  output logic             bnd_hit
);
  localparam logic [WIDTH:0] MAXW = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);
  logic [WIDTH:0] cw, lw;
  sel_e sel;
  always_comb begin
    cw = {1'b0, count};
    lw = {1'b0, load_val};
    sel = clear ? CLR : load ? LOAD : !en ? HOLD :
          up ? (cw == MAXW ? (SATURATE == CNT_SAT ? SAT : WRAP_LO) : INC) :
               (cw == '0 ? (SATURATE == CNT_SAT ? SAT : WRAP_HI) : DEC);
    next_count = WIDTH'(sel == LOAD ? (lw > MAXW ? MAXW : lw) :
                        sel == INC ? cw + ONE :
                        sel == DEC ? cw - ONE :
                        sel == WRAP_HI ? MAXW :
                        (sel == HOLD || sel == SAT) ? cw : '0);
    bnd_hit = sel == WRAP_LO || sel == WRAP_HI || sel == SAT;
  end
endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised wrap/saturate up/down counter with load, clear and overflow flags
module param_updown_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int unsigned MAX_VAL = (1 << WIDTH) - 1,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             bnd_evt,
  output logic             ovf_flag
);
  logic [WIDTH-1:0] next_count;
  logic bnd_hit;
  updown_next_val #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .SATURATE(SATURATE)) u_next (
    .count(count), .up(up), .en(en), .load(load), .load_val(load_val), .clear(clear),
    .next_count(next_count), .bnd_hit(bnd_hit)
  );
  assign tc = up ? count == WIDTH'(MAX_VAL) : count == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      bnd_evt <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      count <= next_count;
      bnd_evt <= bnd_hit;
      ovf_flag <= !clear && (ovf_flag || bnd_hit);
    end
  end
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: four counter configurations checked against a scoreboarded model and fixed vectors
module tb_param_updown_counter;
  import cnt_pkg::*;
  logic clk = 0, reset = 1, clear = 0, load = 0, en = 0, up = 1;
  logic [3:0] load_val = 0;
  logic [3:0] c0, c1, c2;
  logic [0:0] c3;
  logic [3:0] t, b, o;
  always #5 clk = ~clk;
  param_updown_counter #(.WIDTH(4)) d0 (.clk(clk), .reset(reset), .clear(clear), .load(load),
    .load_val(load_val), .en(en), .up(up), .count(c0), .tc(t[0]), .bnd_evt(b[0]), .ovf_flag(o[0]));
  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(CNT_WRAP)) d1 (.clk(clk), .reset(reset),
    .clear(clear), .load(load), .load_val(load_val), .en(en), .up(up), .count(c1), .tc(t[1]),
    .bnd_evt(b[1]), .ovf_flag(o[1]));
  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(CNT_SAT)) d2 (.clk(clk), .reset(reset),
    .clear(clear), .load(load), .load_val(load_val), .en(en), .up(up), .count(c2), .tc(t[2]),
    .bnd_evt(b[2]), .ovf_flag(o[2]));
  param_updown_counter #(.WIDTH(1), .MAX_VAL(1), .SATURATE(CNT_WRAP)) d3 (.clk(clk), .reset(reset),
    .clear(clear), .load(load), .load_val(load_val[0:0]), .en(en), .up(up), .count(c3), .tc(t[3]),
    .bnd_evt(b[3]), .ovf_flag(o[3]));
  typedef struct {
    int c[4];
    logic b[4];
    logic o[4];
    logic t[4];
  } exp_t;
  typedef struct {
    logic r, cl, l;
    logic [3:0] lv;
    logic e, u;
    int ec;
    logic eb, eo;
  } vec_t;
  exp_t q[$];
  int mc[4];
  logic mo[4];
  int mx[4] = '{15, 9, 9, 1};
  int sat[4] = '{0, 0, 1, 0};
  int wm[4] = '{15, 15, 15, 1};
  int checks = 0, errors = 0;
  vec_t tv[14];
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc(input logic r, input logic cl, input logic l, input logic [3:0] lv,
                     input logic e, input logic u);
    exp_t x, y;
    int ac[4];
    int v;
    @(negedge clk);
    reset = r; clear = cl; load = l; load_val = lv; en = e; up = u;
    for (int i = 0; i < 4; i++) begin
      x.b[i] = 0;
      v = int'(lv) & wm[i];
      if (r || cl) begin
        mc[i] = 0;
        mo[i] = 0;
      end else if (l) mc[i] = v > mx[i] ? mx[i] : v;
      else if (e && u) begin
        if (mc[i] == mx[i]) begin
          mc[i] = sat[i] ? mx[i] : 0;
          x.b[i] = 1;
          mo[i] = 1;
        end else mc[i]++;
      end else if (e) begin
        if (mc[i] == 0) begin
          mc[i] = sat[i] ? 0 : mx[i];
          x.b[i] = 1;
          mo[i] = 1;
        end else mc[i]--;
      end
      x.c[i] = mc[i];
      x.o[i] = mo[i];
      x.t[i] = u ? mc[i] == mx[i] : mc[i] == 0;
    end
    q.push_back(x);
    @(posedge clk);
    #1;
    y = q.pop_front();
    ac = '{int'(c0), int'(c1), int'(c2), int'(c3)};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("count%0d", i), ac[i], y.c[i]);
      chk($sformatf("bnd_evt%0d", i), int'(b[i]), int'(y.b[i]));
      chk($sformatf("ovf_flag%0d", i), int'(o[i]), int'(y.o[i]));
      chk($sformatf("tc%0d", i), int'(t[i]), int'(y.t[i]));
    end
  endtask
  initial begin
    tv[0]  = '{1, 0, 0, 4'd0,  0, 1, 0, 0, 0};
    tv[1]  = '{0, 0, 1, 4'd7,  0, 1, 7, 0, 0};
    tv[2]  = '{0, 0, 0, 4'd0,  1, 1, 8, 0, 0};
    tv[3]  = '{0, 0, 0, 4'd0,  1, 1, 9, 0, 0};
    tv[4]  = '{0, 0, 0, 4'd0,  1, 1, 9, 1, 1};
    tv[5]  = '{0, 0, 0, 4'd0,  1, 1, 9, 1, 1};
    tv[6]  = '{0, 0, 0, 4'd0,  1, 1, 9, 1, 1};
    tv[7]  = '{0, 0, 0, 4'd0,  1, 0, 8, 0, 1};
    tv[8]  = '{0, 0, 1, 4'd13, 0, 0, 9, 0, 1};
    tv[9]  = '{0, 0, 1, 4'd3,  1, 1, 3, 0, 1};
    tv[10] = '{0, 1, 1, 4'd5,  1, 1, 0, 0, 0};
    tv[11] = '{0, 0, 0, 4'd0,  0, 0, 0, 0, 0};
    tv[12] = '{0, 0, 0, 4'd0,  1, 0, 0, 1, 1};
    tv[13] = '{1, 0, 1, 4'd6,  1, 1, 0, 0, 0};
    for (int k = 0; k < 14; k++) begin
      cyc(tv[k].r, tv[k].cl, tv[k].l, tv[k].lv, tv[k].e, tv[k].u);
      chk($sformatf("vec%0d_count", k), int'(c2), tv[k].ec);
      chk($sformatf("vec%0d_bnd", k), int'(b[2]), int'(tv[k].eb));
      chk($sformatf("vec%0d_ovf", k), int'(o[2]), int'(tv[k].eo));
    end
    cyc(1, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 1, 1);
    chk("reset_count", int'(c0), 0);
    chk("reset_tc_up", int'(t[0]), 0);
    for (int k = 1; k <= 20; k++) begin
      cyc(0, 0, 0, 0, 1, 1);
      chk($sformatf("up16_count_k%0d", k), int'(c0), k % 16);
      chk($sformatf("up16_bnd_k%0d", k), int'(b[0]), int'(k == 16));
      chk($sformatf("up16_ovf_k%0d", k), int'(o[0]), int'(k >= 16));
      chk($sformatf("tog_count_k%0d", k), int'(c3), k % 2);
      chk($sformatf("tog_bnd_k%0d", k), int'(b[3]), int'(k % 2 == 0));
    end
    cyc(1, 0, 0, 0, 0, 0);
    chk("reset_tc_down", int'(t[1]), 1);
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 0, 0, 0, 1, 0);
      chk($sformatf("dn9_count_k%0d", k), int'(c1), (10 - k % 10) % 10);
      chk($sformatf("dn9_bnd_k%0d", k), int'(b[1]), int'(k == 1 || k == 11));
      chk($sformatf("dn9_tc_k%0d", k), int'(t[1]), int'(k == 10));
    end
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 4'd4, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 1, k % 2 == 0);
      chk($sformatf("dir_count_k%0d", k), int'(c0), k % 2 == 0 ? 5 : 4);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      chk($sformatf("frz_count_k%0d", k), int'(c0), 4);
      chk($sformatf("frz_bnd_k%0d", k), int'(b[0]), 0);
    end
    cyc(0, 0, 1, 4'd5, 0, 1);
    chk("mid_load5", int'(c0), 5);
    cyc(1, 0, 0, 0, 1, 1);
    chk("mid_reset", int'(c0), 0);
    for (int k = 0; k < 300; k++)
      cyc($urandom % 50 == 0, $urandom % 30 == 0, $urandom % 8 == 0, 4'($urandom % 16),
          $urandom % 4 != 0, 1'($urandom % 2));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
